// File: rtl/em_74191.sv
// 74191-style synchronous presettable up/down counter built from cascaded 4-bit stages.
// Stages are chained through their terminal-count flags, the way real packages are cascaded.
module em_74191 #(
  parameter int STAGES = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  nload,
  input  logic                  ncten,
  input  logic                  down,
  input  logic [4*STAGES-1:0]   parallel_in,
  output logic [4*STAGES-1:0]   count,
  output logic                  max_min,
  output logic                  nrco,
  output logic [STAGES-1:0]     stage_tc
);

  logic [4*STAGES-1:0] count_q;
  logic [4*STAGES-1:0] count_d;
  logic [STAGES-1:0]   en;

  // Terminal count per stage depends only on the registered nibble and direction.
  always_comb begin
    stage_tc = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_tc[i] = down ? (count_q[4*i +: 4] == 4'h0)
                         : (count_q[4*i +: 4] == 4'hF);
    end
  end

  always_comb begin : enable_chain
    logic run;
    run = !ncten;
    en  = '0;
    for (int i = 0; i < STAGES; i++) begin
      en[i] = run;
      run   = run & stage_tc[i];
    end
  end

  always_comb begin
    count_d = count_q;
    if (!nload) begin
      count_d = parallel_in;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (en[i]) begin
          count_d[4*i +: 4] = down ? (count_q[4*i +: 4] - 4'd1)
                                   : (count_q[4*i +: 4] + 4'd1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count   = count_q;
  assign max_min = &stage_tc;
  assign nrco    = !(max_min && !ncten);

endmodule

// File: tb/tb_em_74191.sv
// Bench for em_74191 (STAGES=2): directed literal checks plus randomized traffic
// compared every cycle against a whole-counter arithmetic model.
module tb_em_74191;

  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       nload = 1'b1;
  logic       ncten = 1'b1;
  logic       down = 1'b0;
  logic [7:0] parallel_in = 8'h00;
  logic [7:0] count;
  logic       max_min;
  logic       nrco;
  logic [1:0] stage_tc;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  bit model_valid = 1'b0;

  em_74191 #(.STAGES(STAGES)) dut (
    .clk(clk), .clr(clr), .nload(nload), .ncten(ncten), .down(down),
    .parallel_in(parallel_in), .count(count), .max_min(max_min),
    .nrco(nrco), .stage_tc(stage_tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole counter is plain modulo-256 arithmetic.
  always @(posedge clk) begin
    if (clr) begin
      m_cnt <= 0;
      model_valid <= 1'b1;
    end else if (!nload) begin
      m_cnt <= int'(parallel_in);
    end else if (!ncten) begin
      m_cnt <= down ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      bit       e_mm;
      bit [1:0] e_tc;
      int       lo, hi;
      lo = m_cnt % 16;
      hi = m_cnt / 16;
      e_mm = down ? (m_cnt == 0) : (m_cnt == 255);
      e_tc[0] = down ? (lo == 0) : (lo == 15);
      e_tc[1] = down ? (hi == 0) : (hi == 15);
      chk("model_count", count, 8'(m_cnt));
      chk("model_max_min", {7'b0, max_min}, {7'b0, e_mm});
      chk("model_nrco", {7'b0, nrco}, {7'b0, !(e_mm && !ncten)});
      chk("model_stage_tc", {6'b0, stage_tc}, {6'b0, e_tc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    clr = 1'b0; nload = 1'b0; parallel_in = v;
    tick();
    nload = 1'b1;
  endtask

  initial begin
    #1;
    // Reset
    clr = 1'b1; nload = 1'b1; ncten = 1'b1; down = 1'b0;
    tick();
    chk("rst_count", count, 8'h00);
    chk("rst_max_min_up", {7'b0, max_min}, 8'h00);
    chk("rst_nrco_up", {7'b0, nrco}, 8'h01);
    chk("rst_stage_tc_up", {6'b0, stage_tc}, 8'h00);
    down = 1'b1; #1;
    chk("rst_max_min_dn", {7'b0, max_min}, 8'h01);
    chk("rst_stage_tc_dn", {6'b0, stage_tc}, 8'h03);
    chk("rst_nrco_dn_dis", {7'b0, nrco}, 8'h01);
    ncten = 1'b0; #1;
    chk("rst_nrco_dn_en", {7'b0, nrco}, 8'h00);
    ncten = 1'b1; down = 1'b0;

    // Load after reset
    load(8'h3C);
    chk("load_3c", count, 8'h3C);

    // Down wrap
    load(8'h02);
    down = 1'b1; ncten = 1'b0;
    tick(); chk("dn_01", count, 8'h01);
    tick(); chk("dn_00", count, 8'h00);
    chk("dn_00_max_min", {7'b0, max_min}, 8'h01);
    chk("dn_00_nrco", {7'b0, nrco}, 8'h00);
    tick(); chk("dn_ff", count, 8'hFF);

    // Up cascade
    ncten = 1'b1;
    load(8'h0E);
    down = 1'b0; ncten = 1'b0;
    tick(); chk("up_0f", count, 8'h0F);
    chk("up_0f_tc", {6'b0, stage_tc}, 8'h01);
    tick(); chk("up_10", count, 8'h10);
    tick(); chk("up_11", count, 8'h11);

    // Direction flip at terminal
    ncten = 1'b1;
    load(8'hFF);
    down = 1'b0; ncten = 1'b0; #1;
    chk("flip_mm_up", {7'b0, max_min}, 8'h01);
    down = 1'b1; #1;
    chk("flip_mm_dn", {7'b0, max_min}, 8'h00);
    tick(); chk("flip_fe", count, 8'hFE);

    // Hold and priority
    ncten = 1'b1;
    load(8'h55);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_55", count, 8'h55);
      chk("hold_nrco", {7'b0, nrco}, 8'h01);
    end
    clr = 1'b1; nload = 1'b0; parallel_in = 8'hAA;
    tick(); chk("clr_over_load", count, 8'h00);
    clr = 1'b0; nload = 1'b1;

    // Load beats count
    load(8'h10);
    ncten = 1'b0; down = 1'b0; nload = 1'b0; parallel_in = 8'h80;
    tick(); chk("load_over_count", count, 8'h80);
    nload = 1'b1;

    // Randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      clr         = ($urandom_range(0, 63) == 0);
      nload       = ($urandom_range(0, 11) != 0);
      ncten       = ($urandom_range(0, 4) == 0);
      parallel_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) down = ~down;
      // Bias loads toward the wrap boundaries
      if (!nload && $urandom_range(0, 1) == 1)
        parallel_in = down ? 8'($urandom_range(0, 2)) : 8'($urandom_range(253, 255));
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/em_74191.md
# em_74191

Synchronous presettable up/down counter modelled on the 74191 and built from cascaded 4-bit stages. It is the down-counting counterpart to the team's up-only synchronous counter. Typical uses are loadable down-counters for delay timers, loop counters and address decrement in the FEDUC-8 TTL emulation set. Each stage behaves as one 74191 package, and stages are rippled internally through their terminal-count enables, as real packages are chained.

## Interface
- STAGES, 1: number of cascaded 4-bit stages. Counter width is 4*STAGES. Legal range is 1..8.
- clk  in  1  clock; all state changes occur on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- nload  in  1  synchronous parallel load, active-low.
- ncten  in  1  count enable, active-low.
- down  in  1  direction: 0 = count up, 1 = count down.
- parallel_in  in  4*STAGES  load value.
- count  out  4*STAGES  counter value, registered.
- max_min  out  1  terminal count for the current direction. It is not qualified by ncten.
- nrco  out  1  ripple carry/borrow out, active-low. It is low when max_min=1 and ncten=0.
- stage_tc  out  STAGES  per-stage terminal-count flags, for debug and cascading.

## Operation
- Per-stage terminal count stage_tc[i]:
  - When down=0: high when nibble i = 4'hF.
  - When down=1: high when nibble i = 4'h0.
- Stage enable en[i] = !ncten AND stage_tc[0..i-1] all high. en[0] = !ncten.
- Priority at each rising edge of clk, highest first:
  - clr=1: count <= 0.
  - nload=0: count <= parallel_in. This happens regardless of ncten and down.
  - Otherwise, each nibble i with en[i]=1 becomes nibble+1 when down=0, or nibble-1 when down=1, mod 16. Other nibbles hold.
- Whole-counter wrap is therefore modulo 2^(4*STAGES):
  - Up from all-ones goes to 0.
  - Down from 0 goes to all-ones.
- max_min = AND of all stage_tc. It is combinational from count and down.
- nrco = !(max_min AND !ncten). It is combinational and has no pulse shaping.
- Direction change: down is sampled at the same edge as the count. Toggling down changes max_min, stage_tc and nrco immediately, with no extra cycle.
- ncten=1 with nload=1 and clr=0: count holds, and nrco=1.
- Combinational inputs (down, ncten) must not create a loop. stage_tc is derived only from registered count and from down.

## Timing
- Reset values after the clr edge: count=0.
  - down=0 after reset: max_min=0, nrco=1, and stage_tc = all zeros.
  - down=1 after reset: max_min=1, all stage_tc bits are high, and nrco = ncten.
- Load latency is 1 clock: parallel_in is visible on count after the edge where nload=0 is sampled.
- Count latency is 1 clock per step. There is no pipelining of the inter-stage carry, so all stages update on the same edge.
- clr asserted mid-count takes effect on the next edge and overrides a simultaneous load.
- A simultaneous load and enabled count results in the load.
- nrco and max_min change within the same cycle as count, down or ncten. There are no registered flags.

## Test plan
All scenarios use STAGES=2.
- Reset then load:
  - Stimulus: clr=1 for 1 cycle, then nload=0 with parallel_in=8'h3C.
  - Response: count=8'h00 after reset, then 8'h3C one cycle later.
- Down wrap:
  - Stimulus: load 8'h02, down=1, ncten=0, run 3 clocks.
  - Response: count sequence is 01, 00, FF.
  - At count=00, max_min=1 and nrco=0.
- Up cascade:
  - Stimulus: load 8'h0E, down=0, ncten=0, run 3 clocks.
  - Response: count sequence is 0F, 10, 11.
  - At 0F, stage_tc=2'b01. The upper nibble increments only on the 0F->10 edge.
- Direction flip at terminal:
  - Stimulus: count=8'hFF with down=0, giving max_min=1. Set down=1.
  - Response: max_min=0 in the same cycle. The next edge gives 8'hFE.
- Hold and priority:
  - Stimulus: ncten=1 for 4 clocks at 8'h55.
  - Response: count holds at 55 and nrco=1.
  - Then assert clr=1 and nload=0 with parallel_in=8'hAA on the same edge. Response: count=8'h00.
- Load vs count:
  - Stimulus: ncten=0, down=0, count=8'h10, with nload=0 and parallel_in=8'h80 on the same edge.
  - Response: count=8'h80, not 8'h11.
